// File: rtl/sierpinski_row_gen.sv
// Pattern-row generator: Fibonacci LFSR, Galois LFSR or rule-90 automaton with start/stop sequencing.
// Define SIERP_CA_WRAP_EN for a toroidal rule-90 boundary (default: null boundary).
module sierpinski_row_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FTAPS = 8'hB8,
    parameter logic [WIDTH-1:0] GMASK = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] run_len,
    output logic [WIDTH-1:0] row_out,
    output logic             row_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] row_idx,
    output logic             lockup
);

    // state | meaning
    // IDLE  | waiting for start; load still allowed
    // RUN   | one step per en cycle until run_len steps or stop
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_t;

    fsm_t             state_q, state_d;
    logic [WIDTH-1:0] row_q;
    logic [WIDTH-1:0] step_raw;
    logic [WIDTH-1:0] next_row;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_inc;
    logic             valid_q;
    logic             lock_q;
    logic             start_acc;
    logic             step;
    logic             lock_hit;

    assign start_acc = (state_q == IDLE) && start;
    // load and stop both suppress the step in the same cycle
    assign step      = (state_q == RUN) && en && !stop && !load;
    assign idx_inc   = idx_q + CNT_W'(1);

    always_comb begin
        step_raw = '0;
        case (mode_q)
            2'b01:   step_raw = {row_q[WIDTH-2:0], 1'b0} ^ (row_q[WIDTH-1] ? GMASK : '0);
`ifdef SIERP_CA_WRAP_EN
            2'b10:   step_raw = {row_q[WIDTH-2:0], row_q[WIDTH-1]} ^ {row_q[0], row_q[WIDTH-1:1]};
`else
            2'b10:   step_raw = {row_q[WIDTH-2:0], 1'b0} ^ {1'b0, row_q[WIDTH-1:1]};
`endif
            default: step_raw = {row_q[WIDTH-2:0], ^(row_q & FTAPS)};
        endcase
    end

    assign lock_hit = (step_raw == '0);
    assign next_row = lock_hit ? SEED : step_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (stop)
                    state_d = IDLE;
                else if (step && (len_q != '0) && (idx_inc == len_q))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= SEED;
            valid_q <= 1'b0;
            mode_q  <= 2'b00;
            len_q   <= '0;
            idx_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= step;
            if (load)
                row_q <= (seed_in == '0) ? SEED : seed_in;
            else if (step)
                row_q <= next_row;

            if (start_acc) begin
                mode_q <= mode;
                len_q  <= run_len;
                idx_q  <= '0;
            end else if (step) begin
                idx_q  <= idx_inc;
            end

            if (start_acc || load)
                lock_q <= 1'b0;
            else if (step && lock_hit)
                lock_q <= 1'b1;
        end
    end

    assign row_out   = row_q;
    assign row_valid = valid_q;
    assign row_idx   = idx_q;
    assign lockup    = lock_q;

endmodule

// File: tb/tb_sierpinski_row_gen.sv
// Scoreboard bench for sierpinski_row_gen: 8-bit default instance plus a 5-bit instance for lockup.
module tb_sierpinski_row_gen;

    typedef struct {
        logic [7:0] row;
        logic [7:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] seed_in = 8'h00, run_len = 8'h00;
    logic [7:0] row_out, row_idx;
    logic       row_valid, busy, done, lockup;

    logic       en5 = 1'b0, start5 = 1'b0, stop5 = 1'b0, load5 = 1'b0;
    logic [1:0] mode5 = 2'b00;
    logic [4:0] seed5 = 5'h00, row5;
    logic [3:0] len5 = 4'h0, idx5;
    logic       valid5, busy5, done5, lock5;

    exp_t exp_q[$];
    exp_t exp5_q[$];
    int   done_q[$];
    int   done5_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sierpinski_row_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .mode(mode),
        .load(load), .seed_in(seed_in), .run_len(run_len), .row_out(row_out),
        .row_valid(row_valid), .busy(busy), .done(done), .row_idx(row_idx), .lockup(lockup)
    );

    sierpinski_row_gen #(
        .WIDTH(5), .FTAPS(5'h14), .GMASK(5'h05), .SEED(5'h01), .CNT_W(4)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .start(start5), .stop(stop5), .mode(mode5),
        .load(load5), .seed_in(seed5), .run_len(len5), .row_out(row5),
        .row_valid(valid5), .busy(busy5), .done(done5), .row_idx(idx5), .lockup(lock5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] i);
        exp_t e;
        e.row = r;
        e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic launch(input logic ld, input logic [7:0] sd, input logic [1:0] md,
                          input logic [7:0] len);
        load    = ld;
        seed_in = sd;
        mode    = md;
        run_len = len;
        start   = 1'b1;
        cycle();
        load  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || done) && n < 40) begin
            cycle();
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 40), 32'd1);
    endtask

    // monitors: pop one expected row per row_valid, one expected index per done
    always @(negedge clk) begin
        if (rst_n) begin
            if (row_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_row: got row 0x%0h idx %0d expected none", row_out, row_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("row_out", 32'(row_out), 32'(e.row));
                    check("row_idx", 32'(row_idx), 32'(e.idx));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_done: got done at idx %0d expected none", row_idx);
                end else begin
                    check("done_idx", 32'(row_idx), 32'(done_q.pop_front()));
                end
            end
            if (valid5) begin
                if (exp5_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_row5: got row 0x%0h expected none", row5);
                end else begin
                    exp_t e;
                    e = exp5_q.pop_front();
                    check("row5", 32'(row5), 32'(e.row));
                    check("idx5", 32'(idx5), 32'(e.idx));
                end
            end
            if (done5) begin
                if (done5_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_done5: got done at idx %0d expected none", idx5);
                end else begin
                    check("done5_idx", 32'(idx5), 32'(done5_q.pop_front()));
                end
            end
        end
    end

    initial begin
        exp_t e5;
        rst_n = 1'b0;
        #12;
        check("rst_row", 32'(row_out), 32'h01);
        check("rst_valid", 32'(row_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(row_idx), 32'd0);
        check("rst_lockup", 32'(lockup), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Fibonacci from reset seed, 4 steps
        push(8'h02, 8'd1); push(8'h04, 8'd2); push(8'h08, 8'd3); push(8'h11, 8'd4);
        done_q.push_back(4);
        en = 1'b1;
        launch(1'b0, 8'h00, 2'b00, 8'd4);
        check("fib_busy", 32'(busy), 32'd1);
        wait_idle("fib");
        check("fib_idx_hold", 32'(row_idx), 32'd4);
        check("fib_row_hold", 32'(row_out), 32'h11);
        en = 1'b0;

        // Galois with load+start in the same cycle, then zero reseed
        push(8'h1D, 8'd1);
        done_q.push_back(1);
        launch(1'b1, 8'h80, 2'b01, 8'd1);
        check("gal_loaded", 32'(row_out), 32'h80);
        en = 1'b1;
        cycle();
        wait_idle("gal");
        en = 1'b0;
        load = 1'b1; seed_in = 8'h00;
        cycle();
        load = 1'b0;
        check("zero_seed", 32'(row_out), 32'h01);

        // Rule-90 Sierpinski rows
        push(8'h28, 8'd1); push(8'h44, 8'd2); push(8'hAA, 8'd3);
        done_q.push_back(3);
        en = 1'b1;
        launch(1'b1, 8'h10, 2'b10, 8'd3);
        wait_idle("r90");
        en = 1'b0;

        // Rule-90 boundary
`ifdef SIERP_CA_WRAP_EN
        push(8'h82, 8'd1);
`else
        push(8'h02, 8'd1);
`endif
        done_q.push_back(1);
        en = 1'b1;
        launch(1'b1, 8'h01, 2'b10, 8'd1);
        wait_idle("r90_edge");

        // Reserved mode behaves as Fibonacci
        push(8'h11, 8'd1);
        done_q.push_back(1);
        launch(1'b1, 8'h08, 2'b11, 8'd1);
        wait_idle("mode3");
        en = 1'b0;

        // Free-run with en toggling; mode change mid-run is ignored
        push(8'h02, 8'd1); push(8'h04, 8'd2); push(8'h08, 8'd3); push(8'h11, 8'd4);
        push(8'h23, 8'd5);
        launch(1'b1, 8'h01, 2'b00, 8'd0);
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            en = (i % 2 == 0);
            cycle();
        end
        check("free_busy", 32'(busy), 32'd1);
        check("free_idx", 32'(row_idx), 32'd5);
        // load beats a same-cycle step
        en = 1'b1; load = 1'b1; seed_in = 8'h40;
        cycle();
        load = 1'b0;
        check("load_row", 32'(row_out), 32'h40);
        check("load_idx", 32'(row_idx), 32'd5);
        push(8'h80, 8'd6);
        cycle();
        // stop beats en
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_row", 32'(row_out), 32'h80);
        check("stop_idx", 32'(row_idx), 32'd6);
        cycle();
        check("idle_no_step", 32'(row_out), 32'h80);

        // Async reset mid-run
        push(8'h01, 8'd1);
        launch(1'b0, 8'h00, 2'b00, 8'd0);
        cycle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_row", 32'(row_out), 32'h01);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_idx", 32'(row_idx), 32'd0);
        check("arst_valid", 32'(row_valid), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // 5-bit lockup recovery
        e5.row = 8'h01; e5.idx = 8'd1; exp5_q.push_back(e5);
        e5.row = 8'h02; e5.idx = 8'd2; exp5_q.push_back(e5);
        done5_q.push_back(2);
        load5 = 1'b1; seed5 = 5'h15; mode5 = 2'b10; len5 = 4'd2; start5 = 1'b1;
        cycle();
        load5 = 1'b0; start5 = 1'b0; en5 = 1'b1;
        cycle();
        check("lock_set", 32'(lock5), 32'd1);
        for (int i = 0; i < 4; i++) cycle();
        en5 = 1'b0;
        check("lock_sticky", 32'(lock5), 32'd1);
        check("busy5_end", 32'(busy5), 32'd0);
        start5 = 1'b1; len5 = 4'd1;
        cycle();
        start5 = 1'b0;
        check("lock_cleared", 32'(lock5), 32'd0);
        e5.row = 8'h05; e5.idx = 8'd1; exp5_q.push_back(e5);
        done5_q.push_back(1);
        en5 = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        en5 = 1'b0;

        repeat (3) cycle();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("exp5_q_empty", 32'(exp5_q.size()), 32'd0);
        check("done5_q_empty", 32'(done5_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
